btn_debounce_pulse: RTL and testbench

//  Front-end for all front-panel push buttons. Synchronises the raw BTN inputs to clk_1Khz and debounces them.

---
 rtl/btn_debounce_pulse_pkg.sv | 30 +++
 rtl/btn_debounce_pulse_deb_key_fsm.sv | 124 ++++++++++++
 rtl/btn_debounce_pulse.sv | 36 +++
 tb/tb_btn_debounce_pulse.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pulse_pkg.sv
// Shared definitions for the front-panel button front-end: key indices,
// per-key FSM state encoding and default timing constants.
package btn_debounce_pulse_pkg;

    // Bit positions of each physical button inside the btn_* vectors.
    localparam int KEY_BTN0 = 0;
    localparam int KEY_BTN1 = 1;
    localparam int KEY_BTN3 = 2;
    localparam int KEY_BTN4 = 3;
    localparam int KEY_BTN6 = 4;
    localparam int KEY_BTN7 = 5;

    localparam int N_KEYS_DEF          = 6;
    localparam int DEBOUNCE_MS_DEF     = 20;
    localparam int REPEAT_DELAY_MS_DEF = 500;
    localparam int REPEAT_RATE_MS_DEF  = 200;
    localparam int CNT_W_DEF           = 10;

    localparam logic [N_KEYS_DEF-1:0] REPEAT_MASK_DEF =
        (N_KEYS_DEF'(1) << KEY_BTN6) | (N_KEYS_DEF'(1) << KEY_BTN7);

    typedef enum logic [2:0] {
        ST_RELEASED    = 3'd0,
        ST_PRESS_DEB   = 3'd1,
        ST_PRESSED     = 3'd2,
        ST_REPEATING   = 3'd3,
        ST_RELEASE_DEB = 3'd4
    } key_state_e;

endpackage

// File: rtl/btn_debounce_pulse_deb_key_fsm.sv
// One key: 2-FF synchroniser, shared debounce/repeat counter and the
// press/release FSM producing a registered pulse and debounced level.
module deb_key_fsm
    import btn_debounce_pulse_pkg::*;
#(
    parameter int DEBOUNCE_MS     = DEBOUNCE_MS_DEF,
    parameter int REPEAT_DELAY_MS = REPEAT_DELAY_MS_DEF,
    parameter int REPEAT_RATE_MS  = REPEAT_RATE_MS_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk_1Khz,
    input  logic rst,
    input  logic repeat_en,
    input  logic btn_raw,
    output logic btn_pulse,
    output logic btn_level
);

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_MS - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_MS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;

    always_ff @(posedge clk_1Khz or negedge rst) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        s1_d    = btn_raw;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = level_q;
        case (state_q)
            ST_RELEASED: begin
                if (s2_q) begin
                    state_d = ST_PRESS_DEB;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_DEB: begin
                if (!s2_q) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // Non-repeating keys park the counter at its ceiling while held.
            ST_PRESSED: begin
                if (!s2_q) begin
                    state_d = ST_RELEASE_DEB;
                    cnt_d   = '0;
                end else if (repeat_en && (cnt_q == DELAY_LAST)) begin
                    state_d = ST_REPEATING;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_REPEATING: begin
                if (!s2_q) begin
                    state_d = ST_RELEASE_DEB;
                    cnt_d   = '0;
                end else if (cnt_q == RATE_LAST) begin
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RELEASE_DEB: begin
                if (s2_q) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign btn_pulse = pulse_q;
    assign btn_level = level_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Front-panel button front-end: one independent debounce/auto-repeat
// channel per key, auto-repeat enabled per key by REPEAT_MASK.
module btn_debounce_pulse
    import btn_debounce_pulse_pkg::*;
#(
    parameter int                N_KEYS          = N_KEYS_DEF,
    parameter int                DEBOUNCE_MS     = DEBOUNCE_MS_DEF,
    parameter int                REPEAT_DELAY_MS = REPEAT_DELAY_MS_DEF,
    parameter int                REPEAT_RATE_MS  = REPEAT_RATE_MS_DEF,
    parameter logic [N_KEYS-1:0] REPEAT_MASK     = N_KEYS'(REPEAT_MASK_DEF),
    parameter int                CNT_W           = CNT_W_DEF
) (
    input  logic              clk_1Khz,
    input  logic              rst,
    input  logic [N_KEYS-1:0] btn_raw,
    output logic [N_KEYS-1:0] btn_pulse,
    output logic [N_KEYS-1:0] btn_level
);

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        deb_key_fsm #(
            .DEBOUNCE_MS    (DEBOUNCE_MS),
            .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
            .REPEAT_RATE_MS (REPEAT_RATE_MS),
            .CNT_W          (CNT_W)
        ) u_key (
            .clk_1Khz (clk_1Khz),
            .rst      (rst),
            .repeat_en(REPEAT_MASK[k]),
            .btn_raw  (btn_raw[k]),
            .btn_pulse(btn_pulse[k]),
            .btn_level(btn_level[k])
        );
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse: directed key patterns push
// expected pulse cycles, a negedge monitor pops and compares each pulse.
module tb_btn_debounce_pulse;
    import btn_debounce_pulse_pkg::*;

    // Stimulus applied at a negedge with cycle count C is first sampled at
    // posedge C+1; 2 sync stages + 20 debounce + output register -> seen at C+23.
    localparam int LAT = 23;

    logic       clk_1Khz = 1'b0;
    logic       rst;
    logic [5:0] btn_raw;
    logic [5:0] btn_pulse;
    logic [5:0] btn_level;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int stimCyc  = 0;

    typedef struct {
        int         at;
        logic [5:0] pulse;
    } exp_t;

    exp_t       expQ[$];
    exp_t       monE;
    logic [5:0] prevPulse = '0;

    btn_debounce_pulse dut (
        .clk_1Khz (clk_1Khz),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_pulse(btn_pulse),
        .btn_level(btn_level)
    );

    always #5 clk_1Khz = ~clk_1Khz;

    always @(posedge clk_1Khz) cyc <= cyc + 1;

    task automatic applyStimulus(input logic [5:0] val);
        btn_raw = val;
        stimCyc = cyc;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_1Khz);
    endtask

    task automatic expectPulse(input int at, input logic [5:0] mask);
        exp_t e;
        e.at    = at;
        e.pulse = mask;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [5:0] actual, input logic [5:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every nonzero pulse vector must match the next scoreboard entry.
    always @(negedge clk_1Khz) begin
        if (btn_pulse !== 6'b0) begin
            checks++;
            if ((btn_pulse & prevPulse) != 6'b0) begin
                failures++;
                $display("[TB] FAIL pulse_back_to_back: got %b after %b (cycle %0d)", btn_pulse, prevPulse, cyc);
            end else if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_pulse: got %b at cycle %0d, expected none", btn_pulse, cyc);
            end else begin
                monE = expQ.pop_front();
                if (monE.at != cyc || monE.pulse !== btn_pulse) begin
                    failures++;
                    $display("[TB] FAIL pulse_event: got %b at cycle %0d, expected %b at cycle %0d",
                             btn_pulse, cyc, monE.pulse, monE.at);
                end
            end
        end
        prevPulse = btn_pulse;
    end

    initial begin
        logic [5:0] k0, k3k4, k6, k7, kb3;
        int         t0;
        k0   = 6'b1 << KEY_BTN0;
        kb3  = 6'b1 << KEY_BTN3;
        k3k4 = (6'b1 << KEY_BTN0) | (6'b1 << KEY_BTN4);
        k6   = 6'b1 << KEY_BTN6;
        k7   = 6'b1 << KEY_BTN7;

        rst     = 1'b0;
        btn_raw = 6'b0;
        waitCycles(3);
        checkOutput("reset_pulse", btn_pulse, 6'b0);
        checkOutput("reset_level", btn_level, 6'b0);
        rst = 1'b1;
        waitCycles(5);

        // 1: bouncing BTN0, then a solid hold
        $display("[TB] test 1: bouncing press on BTN0");
        applyStimulus(k0);   waitCycles(3);
        applyStimulus(6'b0); waitCycles(3);
        applyStimulus(k0);   waitCycles(3);
        applyStimulus(6'b0); waitCycles(3);
        applyStimulus(k0);
        expectPulse(stimCyc + LAT, k0);
        waitCycles(63);
        checkOutput("t1_level_held", btn_level, k0);
        applyStimulus(6'b0); waitCycles(50);
        checkOutput("t1_level_released", btn_level, 6'b0);

        // 2: short glitch on BTN3 must be ignored
        $display("[TB] test 2: 10-cycle glitch on BTN3");
        applyStimulus(kb3); waitCycles(10);
        checkOutput("t2_level_glitch", btn_level, 6'b0);
        applyStimulus(6'b0); waitCycles(40);
        checkOutput("t2_level_after", btn_level, 6'b0);

        // 3: BTN6 long hold auto-repeats
        $display("[TB] test 3: BTN6 held 1200 cycles");
        applyStimulus(k6);
        t0 = stimCyc;
        expectPulse(t0 + LAT, k6);
        expectPulse(t0 + LAT + 500, k6);
        expectPulse(t0 + LAT + 700, k6);
        expectPulse(t0 + LAT + 900, k6);
        expectPulse(t0 + LAT + 1100, k6);
        waitCycles(1200);
        checkOutput("t3_level_held", btn_level, k6);
        applyStimulus(6'b0);
        waitCycles(22);
        checkOutput("t3_level_before_fall", btn_level, k6);
        waitCycles(1);
        checkOutput("t3_level_fallen", btn_level, 6'b0);
        waitCycles(20);

        // 4: BTN0 long hold never repeats
        $display("[TB] test 4: BTN0 held 1200 cycles");
        applyStimulus(k0);
        expectPulse(stimCyc + LAT, k0);
        waitCycles(1200);
        checkOutput("t4_level_held", btn_level, k0);
        applyStimulus(6'b0); waitCycles(50);
        checkOutput("t4_level_released", btn_level, 6'b0);

        // 5: simultaneous press on BTN0 and BTN4
        $display("[TB] test 5: BTN0 and BTN4 together");
        applyStimulus(k3k4);
        expectPulse(stimCyc + LAT, k3k4);
        waitCycles(40);
        checkOutput("t5_level_held", btn_level, k3k4);
        applyStimulus(6'b0); waitCycles(50);

        // 6: reset while BTN7 is held, key still down afterwards
        $display("[TB] test 6: reset during BTN7 hold");
        applyStimulus(k7);
        t0 = stimCyc;
        expectPulse(t0 + LAT, k7);
        expectPulse(t0 + LAT + 500, k7);
        waitCycles(600);
        checkOutput("t6_level_before_reset", btn_level, k7);
        rst = 1'b0;
        #1;
        checkOutput("t6_pulse_in_reset", btn_pulse, 6'b0);
        checkOutput("t6_level_in_reset", btn_level, 6'b0);
        waitCycles(10);
        rst = 1'b1;
        expectPulse(cyc + LAT, k7);
        waitCycles(40);
        checkOutput("t6_level_after_reset", btn_level, k7);
        applyStimulus(6'b0); waitCycles(50);
        checkOutput("t6_level_released", btn_level, 6'b0);

        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL missing_pulses: %0d still pending, expected 0 (next due cycle %0d)",
                     expQ.size(), expQ[0].at);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
